// File: rtl/prewish5k_multichan_loader.sv
// Multi-channel DIP mask loader.
// Polls an external debouncer for button levels, detects per-channel edges,
// latches the inverted DIP value into a per-channel slot and delivers pending
// slots downstream over a strobe/acknowledge handshake in round-robin order.
module prewish5k_multichan_loader #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned DW         = 8,
  parameter int unsigned POLL_BITS  = 16,
  parameter int unsigned ALIVE_BITS = 23,
  parameter int unsigned EDGE_MODE  = 0,
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK_I,
  input  logic           RST_I,
  output logic           DBN_STB_O,
  input  logic           DBN_ACK_I,
  input  logic [NCH-1:0] DBN_DAT_I,
  input  logic [DW-1:0]  i_dip,
  output logic           STB_O,
  input  logic           ACK_I,
  output logic [DW-1:0]  DAT_O,
  output logic [CW-1:0]  CH_O,
  output logic [NCH-1:0] o_pending,
  output logic           o_overrun,
  output logic           o_timeout,
  output logic           o_alive
);

  typedef enum logic [1:0] {P_IDLE, P_REQ, P_WAIT, P_GAP} poll_state_e;
  typedef enum logic [1:0] {D_IDLE, D_STB, D_GAP} disp_state_e;

  // Poll side
  poll_state_e           poll_state_q, poll_state_d;
  logic [POLL_BITS-1:0]  poll_cnt_q,   poll_cnt_d;
  logic [3:0]            wait_cnt_q,   wait_cnt_d;
  logic [NCH-1:0]        btn_q,        btn_d;
  logic [NCH-1:0]        btn_prev_q,   btn_prev_d;
  logic                  primed_q,     primed_d;
  logic                  cap_q,        cap_d;
  logic                  timeout_q,    timeout_d;
  logic [ALIVE_BITS-1:0] alive_q,      alive_d;

  // Dispatch side
  disp_state_e           disp_q,       disp_d;
  logic [NCH-1:0][DW-1:0] slot_q,      slot_d;
  logic [NCH-1:0]        pending_q,    pending_d;
  logic                  overrun_q,    overrun_d;
  logic [DW-1:0]         dat_q,        dat_d;
  logic [CW-1:0]         ch_q,         ch_d;
  logic [CW-1:0]         last_q,       last_d;

  // Combinational helpers
  logic [NCH-1:0]        rise_vec;
  logic [NCH-1:0]        fall_vec;
  logic [NCH-1:0]        edge_vec;
  logic [NCH-1:0]        req_vec;
  logic                  gnt_found;
  logic [CW-1:0]         gnt_idx;
  logic [DW-1:0]         gnt_dat;

  // Poll FSM: free-running interval counter, one-clock request, bounded wait for the debouncer
  always_comb begin
    poll_state_d = poll_state_q;
    poll_cnt_d   = poll_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    btn_d        = btn_q;
    btn_prev_d   = btn_prev_q;
    primed_d     = primed_q;
    cap_d        = 1'b0;
    timeout_d    = timeout_q;
    alive_d      = alive_q + ALIVE_BITS'(1);
    unique case (poll_state_q)
      P_IDLE: begin
        poll_cnt_d = poll_cnt_q + POLL_BITS'(1);
        if (poll_cnt_q == '1) begin
          poll_state_d = P_REQ;
        end
      end
      P_REQ: begin
        wait_cnt_d   = '0;
        poll_state_d = P_WAIT;
      end
      P_WAIT: begin
        if (DBN_ACK_I) begin
          btn_d        = DBN_DAT_I;
          btn_prev_d   = btn_q;
          cap_d        = primed_q;
          primed_d     = 1'b1;
          poll_state_d = P_GAP;
        end else if (wait_cnt_q == 4'd15) begin
          timeout_d    = 1'b1;
          poll_state_d = P_GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      P_GAP: begin
        poll_state_d = P_IDLE;
      end
      default: poll_state_d = P_IDLE;
    endcase
  end

  // Edge detection, valid only on the clock following a primed capture
  always_comb begin
    rise_vec = btn_q & ~btn_prev_q;
    fall_vec = btn_prev_q & ~btn_q;
    edge_vec = '0;
    if (cap_q) begin
      if (EDGE_MODE == 0) begin
        edge_vec = rise_vec;
      end else if (EDGE_MODE == 1) begin
        edge_vec = fall_vec;
      end else begin
        edge_vec = rise_vec | fall_vec;
      end
    end
  end

  // Round-robin arbiter; edges arriving this clock are visible so a grant can follow an edge directly
  always_comb begin
    req_vec   = pending_q | edge_vec;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      logic [CW-1:0] cand;
      cand = CW'((32'(last_q) + 32'd1 + i) % NCH);
      if (!gnt_found && req_vec[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    gnt_dat = edge_vec[gnt_idx] ? ~i_dip : slot_q[gnt_idx];
  end

  // Dispatch FSM plus slot/pending bookkeeping
  always_comb begin
    disp_d    = disp_q;
    pending_d = pending_q;
    slot_d    = slot_q;
    overrun_d = overrun_q;
    dat_d     = dat_q;
    ch_d      = ch_q;
    last_d    = last_q;
    unique case (disp_q)
      // D_GAP arbitrates as well so back-to-back deliveries have a single idle strobe clock
      D_IDLE, D_GAP: begin
        disp_d = D_IDLE;
        if (gnt_found) begin
          dat_d  = gnt_dat;
          ch_d   = gnt_idx;
          last_d = gnt_idx;
          disp_d = D_STB;
        end
      end
      D_STB: begin
        if (ACK_I) begin
          pending_d[ch_q] = 1'b0;
          disp_d          = D_GAP;
        end
      end
      default: disp_d = D_IDLE;
    endcase
    // Applied after the acknowledge clear so a coinciding edge keeps the channel pending
    for (int unsigned k = 0; k < NCH; k++) begin
      if (edge_vec[k]) begin
        slot_d[k]    = ~i_dip;
        pending_d[k] = 1'b1;
        if (pending_q[k]) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      poll_state_q <= P_IDLE;
      poll_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      btn_q        <= '0;
      btn_prev_q   <= '0;
      primed_q     <= 1'b0;
      cap_q        <= 1'b0;
      timeout_q    <= 1'b0;
      alive_q      <= '0;
      disp_q       <= D_IDLE;
      slot_q       <= '0;
      pending_q    <= '0;
      overrun_q    <= 1'b0;
      dat_q        <= '0;
      ch_q         <= '0;
      last_q       <= CW'(NCH - 1);
    end else begin
      poll_state_q <= poll_state_d;
      poll_cnt_q   <= poll_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      btn_q        <= btn_d;
      btn_prev_q   <= btn_prev_d;
      primed_q     <= primed_d;
      cap_q        <= cap_d;
      timeout_q    <= timeout_d;
      alive_q      <= alive_d;
      disp_q       <= disp_d;
      slot_q       <= slot_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      dat_q        <= dat_d;
      ch_q         <= ch_d;
      last_q       <= last_d;
    end
  end

  assign DBN_STB_O = (poll_state_q == P_REQ);
  assign STB_O     = (disp_q == D_STB);
  assign DAT_O     = dat_q;
  assign CH_O      = ch_q;
  assign o_pending = pending_q;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;
  assign o_alive   = alive_q[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish5k_multichan_loader.sv
// Directed self-checking bench for prewish5k_multichan_loader
// (NCH=4, DW=8, POLL_BITS=3, ALIVE_BITS=4, press-edge mode).
module tb_prewish5k_multichan_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dbn_stb;
  logic       dbn_ack;
  logic [3:0] dbn_dat;
  logic [7:0] dip;
  logic       stb;
  logic       ack;
  logic [7:0] dat;
  logic [1:0] ch;
  logic [3:0] pending;
  logic       overrun;
  logic       timeout;
  logic       alive;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned stage = 0;
  bit          auto_en  = 1'b1;
  bit          captured = 1'b0;

  always #5 clk = ~clk;

  prewish5k_multichan_loader #(
    .NCH(4), .DW(8), .POLL_BITS(3), .ALIVE_BITS(4), .EDGE_MODE(0)
  ) dut (
    .CLK_I(clk), .RST_I(rst_n),
    .DBN_STB_O(dbn_stb), .DBN_ACK_I(dbn_ack), .DBN_DAT_I(dbn_dat),
    .i_dip(dip),
    .STB_O(stb), .ACK_I(ack), .DAT_O(dat), .CH_O(ch),
    .o_pending(pending), .o_overrun(overrun), .o_timeout(timeout), .o_alive(alive)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; also plays the debouncer: ack one clock after seeing the request
  task automatic tick();
    @(posedge clk);
    #1;
    captured = 1'b0;
    if (auto_en) begin
      case (stage)
        1: begin dbn_ack = 1'b1; stage = 2; end
        2: begin dbn_ack = 1'b0; stage = 0; captured = 1'b1; end
        default: if (dbn_stb) stage = 1;
      endcase
    end
  endtask

  task automatic wait_capture(input string tag);
    int unsigned n = 0;
    captured = 1'b0;
    while (!captured && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(captured), 32'd1);
  endtask

  task automatic wait_dbn_stb(output int unsigned n);
    n = 0;
    while (!dbn_stb && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bit seen;
    rst_n   = 1'b0;
    dbn_ack = 1'b0;
    dbn_dat = 4'b0001;
    dip     = 8'hF0;
    ack     = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_stb", 32'(stb), 32'd0);
    chk("rst_dbn_stb", 32'(dbn_stb), 32'd0);
    chk("rst_dat", 32'(dat), 32'h00);
    chk("rst_ch", 32'(ch), 32'd0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_alive", 32'(alive), 32'd0);

    // First poll: 8 clocks after release, one-clock request, priming capture only
    rst_n = 1'b1;
    wait_dbn_stb(n);
    chk("poll_first_delay", n, 32'd8);
    chk("alive_msb", 32'(alive), 32'd1);
    tick();
    chk("poll_one_cycle", 32'(dbn_stb), 32'd0);
    wait_capture("cap_prime");
    n = 0;
    seen = 1'b0;
    while (!dbn_stb && n < 40) begin
      tick();
      n++;
      if (stb) seen = 1'b1;
    end
    chk("poll_gap_after_cap", n, 32'd9);
    chk("prime_no_stb", 32'(seen), 32'd0);
    chk("prime_no_pending", 32'(pending), 32'h0);

    // Release ch0 (no edge in press mode), then press ch0
    dbn_dat = 4'b0000;
    wait_capture("cap_release0");
    tick();
    chk("release_no_stb", 32'(stb), 32'd0);
    chk("release_no_pending", 32'(pending), 32'h0);
    dbn_dat = 4'b0001;
    wait_capture("cap_press0");
    chk("press0_lat0", 32'(stb), 32'd0);
    tick();
    chk("press0_stb", 32'(stb), 32'd1);
    chk("press0_dat", 32'(dat), 32'h0F);
    chk("press0_ch", 32'(ch), 32'd0);
    chk("press0_pending", 32'(pending), 32'h1);
    repeat (3) tick();
    chk("press0_hold_stb", 32'(stb), 32'd1);
    chk("press0_hold_dat", 32'(dat), 32'h0F);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("press0_ack_stb", 32'(stb), 32'd0);
    chk("press0_ack_pending", 32'(pending), 32'h0);

    // ch1 and ch3 in one poll with the acknowledge tied high
    ack = 1'b1;
    dbn_dat = 4'b1011;
    wait_capture("cap_press13");
    tick();
    chk("rr_first_stb", 32'(stb), 32'd1);
    chk("rr_first_ch", 32'(ch), 32'd1);
    chk("rr_both_pending", 32'(pending), 32'hA);
    tick();
    chk("rr_gap_stb", 32'(stb), 32'd0);
    tick();
    chk("rr_second_stb", 32'(stb), 32'd1);
    chk("rr_second_ch", 32'(ch), 32'd3);
    chk("rr_second_dat", 32'(dat), 32'h0F);
    tick();
    chk("rr_done_stb", 32'(stb), 32'd0);
    chk("rr_done_pending", 32'(pending), 32'h0);
    ack = 1'b0;

    // ch2 pressed twice while its delivery is unacknowledged
    dip = 8'hA5;
    dbn_dat = 4'b1111;
    wait_capture("cap_press2a");
    tick();
    chk("ovr_first_ch", 32'(ch), 32'd2);
    chk("ovr_first_dat", 32'(dat), 32'h5A);
    dbn_dat = 4'b1011;
    wait_capture("cap_release2");
    tick();
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    dip = 8'h3C;
    dbn_dat = 4'b1111;
    wait_capture("cap_press2b");
    tick();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_stb_held", 32'(stb), 32'd1);
    chk("ovr_dat_held", 32'(dat), 32'h5A);
    chk("ovr_pending", 32'(pending), 32'h4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ovr_ack_stb", 32'(stb), 32'd0);
    chk("ovr_ack_dat", 32'(dat), 32'h5A);
    chk("ovr_ack_pending", 32'(pending), 32'h0);
    dbn_dat = 4'b1011;
    wait_capture("cap_release2b");
    dbn_dat = 4'b1111;
    wait_capture("cap_press2c");
    tick();
    chk("ovr_second_stb", 32'(stb), 32'd1);
    chk("ovr_second_dat", 32'(dat), 32'hC3);
    chk("ovr_second_ch", 32'(ch), 32'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    // Debouncer never answers: timeout after 16 clocks in the wait state, sample discarded
    wait_capture("cap_pre_timeout");
    auto_en = 1'b0;
    dbn_ack = 1'b0;
    dbn_dat = 4'b0000;
    chk("to_clear_before", 32'(timeout), 32'd0);
    wait_dbn_stb(n);
    chk("to_req_delay", n, 32'd9);
    repeat (16) tick();
    chk("to_not_early", 32'(timeout), 32'd0);
    tick();
    chk("to_set", 32'(timeout), 32'd1);
    dbn_dat = 4'b1111;
    auto_en = 1'b1;
    wait_dbn_stb(n);
    chk("to_resume_delay", n, 32'd9);
    wait_capture("cap_after_timeout");
    tick();
    chk("to_discard_no_stb", 32'(stb), 32'd0);
    chk("to_discard_no_pending", 32'(pending), 32'h0);
    repeat (5) tick();
    chk("to_sticky", 32'(timeout), 32'd1);
    chk("ovr_sticky", 32'(overrun), 32'd1);

    // Reset during an active strobe
    dbn_dat = 4'b1110;
    wait_capture("cap_release0b");
    dbn_dat = 4'b1111;
    wait_capture("cap_press0b");
    tick();
    chk("mid_stb_before", 32'(stb), 32'd1);
    chk("mid_ch_before", 32'(ch), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_stb_drop", 32'(stb), 32'd0);
    chk("mid_dbn_stb_drop", 32'(dbn_stb), 32'd0);
    chk("mid_pending_clr", 32'(pending), 32'h0);
    chk("mid_dat_clr", 32'(dat), 32'h00);
    chk("mid_overrun_clr", 32'(overrun), 32'd0);
    chk("mid_timeout_clr", 32'(timeout), 32'd0);
    stage   = 0;
    dbn_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (stb) seen = 1'b1;
    end
    chk("post_rst_no_delivery", 32'(seen), 32'd0);
    chk("post_rst_pending", 32'(pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
